apb_i2c_sequencer: RTL and testbench
====================================

APB_I2C_SEQUENCER -- requirements
Module: apb_i2c_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, max cycles spent in any single wait (PREADY, tx_valid, RX-not-empty) before abort.
REQ-002 PCLK  in  1  single clock, all state updates on rising edge.
REQ-003 PRESETn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to run one sequence; ignored unless idle.
REQ-005 cfg_word, tmo_word  in  14 each  values written to CONFIG (addr 8) and TIMEOUT (addr 12).
REQ-006 tx_len, rx_len  in  8 each  number of TX words to push and RX words to pop (0 allowed).
REQ-007 tx_data  in  32, tx_valid  in  1, tx_ready  out  1  TX word stream; a word transfers when tx_valid and tx_ready are both high.
REQ-008 rx_data  out  32, rx_valid  out  1  popped RX word, rx_valid a one-cycle pulse.
REQ-009 busy  out  1  high from the cycle after an accepted start through the last cycle before done.
REQ-010 done  out  1, error  out  1  one-cycle completion pulse; error is high in the same cycle as done when the sequence aborted.
REQ-011 PSELx, PENABLE, PWRITE  out  1 each; PADDR, PWDATA  out  32 each  APB master to the bridge.
REQ-012 PRDATA  in  32, PREADY  in  1, PSLVERR  in  1  APB completion signals from the bridge.
REQ-013 INT_TX  in  1 (TX FIFO empty), INT_RX  in  1 (RX FIFO empty).

Function
REQ-014 States SHALL be IDLE, SETUP, ACCESS, TXWAIT, RXWAIT, FINISH; a phase register (CFG, TMO, TX, RX) selects address and data.
REQ-015 IDLE + start SHALL latch cfg_word, tmo_word, tx_len and rx_len, load phase=CFG, and go to SETUP.
REQ-016 SETUP SHALL drive PSELx=1 and PENABLE=0 with PADDR, PWRITE and PWDATA stable, then go to ACCESS on the next cycle.
REQ-017 ACCESS SHALL drive PSELx=1 and PENABLE=1 and hold PADDR, PWRITE and PWDATA until PREADY=1.
REQ-018 The transfer completes in the ACCESS cycle where PREADY=1; PSELx and PENABLE SHALL drop in the following cycle unless a back-to-back SETUP follows.
REQ-019 Phase CFG: write addr 8, PWDATA={18'b0,cfg}. Phase TMO: write addr 12, PWDATA={18'b0,tmo}.
REQ-020 After TMO completes, the sequencer SHALL go to TXWAIT if tx_len>0, else to RXWAIT if rx_len>0, else to FINISH.
REQ-021 TXWAIT SHALL assert tx_ready; the accepting cycle registers tx_data into PWDATA and starts a SETUP write to addr 0. tx_ready SHALL be low in every other state.
REQ-022 After each TX write the remaining TX count SHALL decrement; at 0 the sequencer SHALL move to RXWAIT (rx_len>0) or to FINISH.
REQ-023 RXWAIT SHALL wait for INT_RX=0 and then start a SETUP read of addr 4 (PWRITE=0).
REQ-024 On read completion, rx_data SHALL be PRDATA sampled in the PREADY cycle, with rx_valid pulsed in the next cycle and the remaining RX count decremented.
REQ-025 PSLVERR=1 in a completing ACCESS cycle SHALL abort: go to FINISH with the error flag set, and perform no further transfers.
REQ-026 A wait counter SHALL clear on every state entry and increment in ACCESS, TXWAIT and RXWAIT; reaching WAIT_LIMIT SHALL abort as in REQ-025 with PSELx and PENABLE dropped.
REQ-027 FINISH SHALL pulse done for one cycle (error=flag), then return to IDLE.
REQ-028 A start arriving while not in IDLE SHALL be ignored; start in the same cycle as FINISH SHALL also be ignored.
REQ-029 Counters SHALL be 8-bit with no wrap: a decrement occurs only from a nonzero value.

Reset
REQ-030 PRESETn low SHALL asynchronously force IDLE and clear PSELx, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_data, rx_valid, busy, done, error and all counters to 0, including mid-transfer.
REQ-031 After PRESETn rises, the block SHALL not act until the next start.

Verification
REQ-032 cfg=0x1234&0x3FFF, tmo=0x0100, tx_len=0, rx_len=0, PREADY tied 1 -> writes addr 8 then addr 12, each 2 cycles, then done=1, error=0.
REQ-033 tx_len=3, tx_valid held with words A,B,C -> three writes to addr 0 with PWDATA A,B,C in order, and tx_ready high for exactly 3 accept cycles.
REQ-034 rx_len=2, INT_RX=1 for 10 cycles then 0, PRDATA=0xCAFE0001 then 0xCAFE0002 -> no read while INT_RX=1, then two rx_valid pulses with matching rx_data.
REQ-035 PSLVERR=1 on the TMO write -> no TX or RX transfers, done=1 with error=1.
REQ-036 PREADY stuck 0 on the CFG write, WAIT_LIMIT=255 -> abort after 255 ACCESS cycles with done=1, error=1, and PSELx=0.
REQ-037 PRESETn pulsed low during an ACCESS cycle -> all outputs 0 immediately, and a following start runs a full clean sequence.

Source files
------------

// File: rtl/apb_i2c_sequencer.sv
// APB master that programs an I2C bridge (CONFIG, TIMEOUT), pushes TX words into its
// data register and pops RX words, aborting on PSLVERR or on any wait that runs too long.
module apb_i2c_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [13:0] cfg_word,
  input  logic [13:0] tmo_word,
  input  logic [7:0]  tx_len,
  input  logic [7:0]  rx_len,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        INT_TX,
  input  logic        INT_RX,
  output logic [2:0]  o_dbg_state,
  output logic        o_dbg_tx_empty
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_TXWAIT = 3'd3,
    S_RXWAIT = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_CFG = 2'd0,
    PH_TMO = 2'd1,
    PH_TX  = 2'd2,
    PH_RX  = 2'd3
  } phase_t;

  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT_M1 = WW'(WAIT_LIMIT - 1);

  state_t        r_state;
  phase_t        r_phase;
  logic [13:0]   r_tmo;
  logic [7:0]    r_tx_cnt;
  logic [7:0]    r_rx_cnt;
  logic [WW-1:0] r_wait;

  logic          w_wait_hit;
  logic          w_abort;
  logic [7:0]    w_tx_rem;
  logic [7:0]    w_rx_rem;

  // Handshake: a TX word moves on a rising edge where tx_valid and tx_ready are both
  // high; tx_ready is registered and high only while parked in TXWAIT.
  assign w_wait_hit = (r_wait == LIMIT_M1);
  assign w_tx_rem   = (r_phase == PH_TX && r_tx_cnt != 8'd0) ? r_tx_cnt - 8'd1 : r_tx_cnt;
  assign w_rx_rem   = (r_phase == PH_RX && r_rx_cnt != 8'd0) ? r_rx_cnt - 8'd1 : r_rx_cnt;

  assign o_dbg_state = r_state;

  always_comb begin
    w_abort = 1'b0;
    case (r_state)
      S_ACCESS: w_abort = PREADY ? PSLVERR : w_wait_hit;
      S_TXWAIT: w_abort = !(tx_valid && tx_ready) && w_wait_hit;
      S_RXWAIT: w_abort = INT_RX && w_wait_hit;
      default:  w_abort = 1'b0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state        <= S_IDLE;
      r_phase        <= PH_CFG;
      r_tmo          <= '0;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      r_wait         <= '0;
      tx_ready       <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      PSELx          <= 1'b0;
      PENABLE        <= 1'b0;
      PWRITE         <= 1'b0;
      PADDR          <= '0;
      PWDATA         <= '0;
      o_dbg_tx_empty <= 1'b0;
    end else begin
      rx_valid       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      r_wait         <= '0;
      o_dbg_tx_empty <= INT_TX;
      if (w_abort) begin
        PSELx    <= 1'b0;
        PENABLE  <= 1'b0;
        tx_ready <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        error    <= 1'b1;
        r_state  <= S_FINISH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_tmo    <= tmo_word;
              r_tx_cnt <= tx_len;
              r_rx_cnt <= rx_len;
              r_phase  <= PH_CFG;
              PADDR    <= 32'd8;
              PWRITE   <= 1'b1;
              PWDATA   <= {18'b0, cfg_word};
              PSELx    <= 1'b1;
              PENABLE  <= 1'b0;
              busy     <= 1'b1;
              r_state  <= S_SETUP;
            end
          end
          S_SETUP: begin
            PENABLE <= 1'b1;
            r_state <= S_ACCESS;
          end
          S_ACCESS: begin
            if (PREADY) begin
              r_tx_cnt <= w_tx_rem;
              r_rx_cnt <= w_rx_rem;
              PENABLE  <= 1'b0;
              if (r_phase == PH_RX) begin
                rx_data  <= PRDATA;
                rx_valid <= 1'b1;
              end
              if (r_phase == PH_CFG) begin
                // CONFIG and TIMEOUT go out back to back with PSELx held high
                r_phase <= PH_TMO;
                PADDR   <= 32'd12;
                PWDATA  <= {18'b0, r_tmo};
                r_state <= S_SETUP;
              end else begin
                PSELx <= 1'b0;
                if (w_tx_rem != 8'd0) begin
                  tx_ready <= 1'b1;
                  r_state  <= S_TXWAIT;
                end else if (w_rx_rem != 8'd0) begin
                  r_state <= S_RXWAIT;
                end else begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_FINISH;
                end
              end
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
          S_TXWAIT: begin
            if (tx_valid && tx_ready) begin
              tx_ready <= 1'b0;
              r_phase  <= PH_TX;
              PADDR    <= 32'd0;
              PWRITE   <= 1'b1;
              PWDATA   <= tx_data;
              PSELx    <= 1'b1;
              r_state  <= S_SETUP;
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
          S_RXWAIT: begin
            if (!INT_RX) begin
              r_phase <= PH_RX;
              PADDR   <= 32'd4;
              PWRITE  <= 1'b0;
              PWDATA  <= '0;
              PSELx   <= 1'b1;
              r_state <= S_SETUP;
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_i2c_sequencer.sv
// Bench for apb_i2c_sequencer: random bridge/stream behaviour, a transaction-list model
// of each sequence, and a negedge monitor that pops expectations as the DUT produces them.
module tb_apb_i2c_sequencer;

  localparam int WAIT_LIMIT = 255;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        start;
  logic [13:0] cfg_word, tmo_word;
  logic [7:0]  tx_len, rx_len;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, busy, done, error;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, INT_TX, INT_RX;
  logic [2:0]  dbg_state;
  logic        dbg_tx_empty;

  apb_i2c_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start),
    .cfg_word(cfg_word), .tmo_word(tmo_word), .tx_len(tx_len), .rx_len(rx_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .error(error),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_TX(INT_TX), .INT_RX(INT_RX),
    .o_dbg_state(dbg_state), .o_dbg_tx_empty(dbg_tx_empty)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard queues: APB entries are {write, addr, data} with data 0 for reads
  logic [64:0] exp_apb_q[$];
  logic [31:0] exp_rx_q[$];
  logic        exp_done_q[$];
  logic [31:0] tx_src_q[$];
  logic [31:0] rd_src_q[$];

  int sl_wmax    = 0;
  bit sl_stuck   = 0;
  int sl_err_idx = -1;
  int sl_idx     = 0;
  int sl_w       = 0;
  bit tx_gappy   = 0;
  bit rx_force   = 0;
  bit cafe_mode  = 0;
  bit tx_acc     = 0;

  int mon_access = 0;
  int mon_txacc  = 0;
  int mon_txr    = 0;
  int mon_reads  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB bridge model: random wait states, PSLVERR on a chosen transfer index
  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(posedge PCLK); #1;
      PREADY = 1'b0; PSLVERR = 1'b0;
      if (PSELx && !PENABLE) begin
        sl_w = sl_stuck ? 1000000 : $urandom_range(0, sl_wmax);
      end else if (PSELx && PENABLE) begin
        if (sl_w == 0) begin
          PREADY  = 1'b1;
          PSLVERR = (sl_idx == sl_err_idx);
          sl_idx++;
          if (!PWRITE) PRDATA = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : 32'hDEAD_BEEF;
          else PRDATA = $urandom();
        end else begin
          sl_w--;
        end
      end
    end
  end

  // FIFO status flags
  initial begin
    INT_TX = 1'b1; INT_RX = 1'b1;
    forever begin
      @(posedge PCLK); #1;
      INT_TX = 1'($urandom_range(0, 1));
      INT_RX = rx_force ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  // TX stream driver
  initial begin
    tx_valid = 1'b0; tx_data = '0;
    forever begin
      @(negedge PCLK);
      tx_acc = tx_valid && tx_ready;
      @(posedge PCLK); #1;
      if (tx_acc && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      tx_valid = (tx_src_q.size() > 0) && (!tx_gappy || $urandom_range(0, 1) == 1);
      tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : $urandom();
    end
  end

  // monitor
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge PCLK);
      if (PENABLE) check("penable_implies_psel", PSELx, 1'b1);
      if (PSELx && PENABLE) mon_access++;
      if (PSELx && !PENABLE && !PWRITE) mon_reads++;
      if (tx_ready) mon_txr++;
      if (tx_valid && tx_ready) mon_txacc++;
      if (PSELx && PENABLE && PREADY) begin
        if (exp_apb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL apb_unexpected: got write=%0b addr=%0h data=%0h expected no transfer", PWRITE, PADDR, PWDATA);
        end else begin
          e = exp_apb_q.pop_front();
          check("apb_xfer", {PWRITE, PADDR, PWRITE ? PWDATA : 32'h0}, e);
        end
      end
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx_q.pop_front());
        end
      end
      if (done) begin
        check("busy_low_at_done", busy, 1'b0);
        if (exp_done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done_unexpected: got error=%0b expected no done", error);
        end else begin
          check("done_error", error, exp_done_q.pop_front());
        end
      end
    end
  end

  task automatic run_seq(input logic [13:0] cfg, input logic [13:0] tmo, input int txl, input int rxl,
                         input int err_idx, input bit stuck, input int rx_hold, input bit fin_start,
                         output int cyc);
    logic [64:0] xfers[$];
    logic [31:0] rdw[$];
    logic [31:0] w;
    int  exp_acc;
    int  busy_gap;
    bit  aborted;
    bit  got_done;
    exp_acc = 0; busy_gap = 0; aborted = 0; got_done = 0;
    @(negedge PCLK);
    exp_apb_q.delete(); exp_rx_q.delete(); exp_done_q.delete();
    tx_src_q.delete(); rd_src_q.delete();
    // reference: the ordered list of transfers one sequence is supposed to make
    xfers.push_back({1'b1, 32'd8, {18'b0, cfg}});
    xfers.push_back({1'b1, 32'd12, {18'b0, tmo}});
    for (int i = 0; i < txl; i++) begin
      w = $urandom();
      tx_src_q.push_back(w);
      xfers.push_back({1'b1, 32'd0, w});
    end
    for (int i = 0; i < rxl; i++) begin
      w = cafe_mode ? 32'hCAFE0001 + i : $urandom();
      rd_src_q.push_back(w);
      rdw.push_back(w);
      xfers.push_back({1'b0, 32'd4, 32'd0});
    end
    if (stuck) begin
      exp_done_q.push_back(1'b1);
    end else begin
      int r;
      r = 0;
      foreach (xfers[i]) begin
        if (!aborted) begin
          exp_apb_q.push_back(xfers[i]);
          if (xfers[i][64:32] == {1'b1, 32'd0}) exp_acc++;
          if (i == err_idx) aborted = 1;
          else if (!xfers[i][64]) begin
            exp_rx_q.push_back(rdw[r]);
            r++;
          end
        end
      end
      exp_done_q.push_back(aborted);
    end
    sl_idx = 0; sl_err_idx = err_idx; sl_stuck = stuck; rx_force = (rx_hold > 0);
    mon_access = 0; mon_txacc = 0; mon_txr = 0; mon_reads = 0;
    cfg_word = cfg; tmo_word = tmo; tx_len = 8'(txl); rx_len = 8'(rxl);
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    cfg_word = 14'($urandom()); tmo_word = 14'($urandom());
    tx_len = 8'($urandom()); rx_len = 8'($urandom());
    cyc = 0;
    while (cyc < 3000 && !got_done) begin
      @(negedge PCLK);
      cyc++;
      if (done) begin
        got_done = 1;
      end else begin
        if (!busy) busy_gap++;
        if (rx_hold > 0 && cyc == rx_hold) begin
          check("no_read_while_rx_empty", mon_reads, 0);
          rx_force = 0;
        end
        start = !fin_start && ($urandom_range(0, 15) == 0);
      end
    end
    start = fin_start;
    if (!got_done) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end else begin
      check("busy_through_sequence", busy_gap, 0);
      check("psel_low_at_done", {PSELx, PENABLE}, 2'b00);
    end
    if (fin_start) begin
      @(posedge PCLK); #1;
      start = 1'b0;
    end
    repeat (4) @(negedge PCLK);
    check("idle_after_done", {PSELx, PENABLE, busy, tx_ready}, 4'b0000);
    check("scoreboard_drained", exp_apb_q.size() + exp_rx_q.size() + exp_done_q.size(), 0);
    if (!stuck) check("tx_accept_count", mon_txacc, exp_acc);
    rx_force = 0; sl_stuck = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected finish before 900000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int txl;
    int rxl;
    int eidx;
    PRESETn = 1'b0; start = 1'b0; cfg_word = '0; tmo_word = '0; tx_len = '0; rx_len = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    check("reset_outputs", {PSELx, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_data,
                            rx_valid, busy, done, error}, 0);

    // config-only sequence with zero wait states
    sl_wmax = 0; tx_gappy = 0;
    run_seq(14'h1234, 14'h0100, 0, 0, -1, 0, 0, 0, cyc);
    check("cfg_only_latency", cyc, 5);

    // three TX words with tx_valid held
    run_seq(14'($urandom()), 14'($urandom()), 3, 0, -1, 0, 0, 0, cyc);
    check("tx_ready_cycles", mon_txr, 3);

    // RX FIFO empty for a while, then two reads
    cafe_mode = 1;
    run_seq(14'($urandom()), 14'($urandom()), 0, 2, -1, 0, 15, 0, cyc);
    cafe_mode = 0;
    check("rx_read_count", mon_reads, 2);

    // slave error on the TIMEOUT write
    run_seq(14'($urandom()), 14'($urandom()), 2, 2, 1, 0, 0, 0, cyc);
    check("no_reads_after_error", mon_reads, 0);

    // PREADY stuck low on the CONFIG write
    run_seq(14'($urandom()), 14'($urandom()), 1, 1, -1, 1, 0, 0, cyc);
    check("access_cycles_before_abort", mon_access, WAIT_LIMIT);

    // start held during FINISH must not launch a new sequence
    sl_wmax = 2;
    run_seq(14'($urandom()), 14'($urandom()), 1, 1, -1, 0, 0, 1, cyc);

    // asynchronous reset in the middle of an ACCESS phase
    @(negedge PCLK);
    exp_apb_q.delete(); exp_rx_q.delete(); exp_done_q.delete(); tx_src_q.delete();
    sl_stuck = 1; sl_err_idx = -1;
    cfg_word = 14'h2AAA; tmo_word = 14'h1555; tx_len = 8'd1; rx_len = 8'd1;
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    repeat (4) @(negedge PCLK);
    check("in_access_before_reset", {PSELx, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("async_reset_outputs", {PSELx, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_data,
                                  rx_valid, busy, done, error}, 0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; sl_stuck = 0;
    repeat (5) @(negedge PCLK);
    check("quiet_after_reset", {PSELx, busy, done}, 3'b000);
    run_seq(14'($urandom()), 14'($urandom()), 2, 2, -1, 0, 0, 0, cyc);

    // randomized sequences
    for (int n = 0; n < 30; n++) begin
      sl_wmax  = $urandom_range(0, 3);
      tx_gappy = 1'($urandom_range(0, 1));
      txl      = $urandom_range(0, 4);
      rxl      = $urandom_range(0, 4);
      eidx     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + txl + rxl) : -1;
      run_seq(14'($urandom()), 14'($urandom()), txl, rxl, eidx, 0, 0, 0, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
